// File: rtl/key_scan_pkg.sv
// rtl/key_scan_pkg.sv - shared types, board timing defaults and width helpers for key_scan
package key_scan_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } key_state_t;

   // Defaults for a 50 MHz board clock.
   localparam int unsigned DEF_N_KEYS          = 4;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms
   localparam int unsigned DEF_REPEAT_EN       = 1;
   localparam int unsigned DEF_REPEAT_DELAY    = 25000000;  // 500 ms
   localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;   // 100 ms

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Counter width able to hold 0 .. n-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: synchronizer, debounce FSM, auto-repeat, registered events
module key_debounce_ch
   import key_scan_pkg::*;
#(
   parameter int unsigned DebounceCycles = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned RepeatEn       = DEF_REPEAT_EN,
   parameter int unsigned RepeatDelay    = DEF_REPEAT_DELAY,
   parameter int unsigned RepeatPeriod   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rstn,
   input  logic key_i,
   output logic key_level_o,
   output logic key_press_o,
   output logic key_release_o,
   output logic key_repeat_o
);

   localparam int unsigned DW = cnt_width(DebounceCycles);
   localparam int unsigned RW = cnt_width(max_u(RepeatDelay, RepeatPeriod));

   localparam logic [DW-1:0] DCNT_LAST = DW'(DebounceCycles - 1);
   localparam logic [DW-1:0] DCNT_ONE  = DW'(1);
   localparam logic [RW-1:0] RD_LAST   = RW'(RepeatDelay - 1);
   localparam logic [RW-1:0] RP_LAST   = RW'(RepeatPeriod - 1);
   localparam logic [RW-1:0] RCNT_ONE  = RW'(1);

   logic          sync1_q, sync2_q;
   logic          key_on;
   key_state_t    state_q, state_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic          first_q, first_d;
   logic          press_ev_q, press_ev_d;
   logic          release_ev_q, release_ev_d;
   logic          repeat_ev_q, repeat_ev_d;
   logic          level_q, press_q, release_q, repeat_q;

   // Two-flop synchronizer; idles at 1 because the raw button is active-low.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
      end
   end

   assign key_on = ~sync2_q;

   // Next state: integrating debounce in both directions, repeat counter only advances in HELD.
   always_comb begin
      state_d      = state_q;
      dcnt_d       = dcnt_q;
      rcnt_d       = rcnt_q;
      first_d      = first_q;
      press_ev_d   = 1'b0;
      release_ev_d = 1'b0;
      repeat_ev_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (key_on) begin
               state_d = PRESS_DB;
               dcnt_d  = DCNT_ONE;
            end
         end
         PRESS_DB: begin
            if (!key_on) begin
               // A bounce throws away the partial window.
               state_d = IDLE;
               dcnt_d  = '0;
            end else if (dcnt_q == DCNT_LAST) begin
               state_d    = HELD;
               dcnt_d     = '0;
               rcnt_d     = '0;
               first_d    = 1'b1;
               press_ev_d = 1'b1;
            end else begin
               dcnt_d = dcnt_q + DCNT_ONE;
            end
         end
         HELD: begin
            if (!key_on) begin
               // rcnt is frozen so a short glitch only delays the repeat cadence.
               state_d = REL_DB;
               dcnt_d  = DCNT_ONE;
            end else if (RepeatEn != 0) begin
               if (rcnt_q == (first_q ? RD_LAST : RP_LAST)) begin
                  repeat_ev_d = 1'b1;
                  rcnt_d      = '0;
                  first_d     = 1'b0;
               end else begin
                  rcnt_d = rcnt_q + RCNT_ONE;
               end
            end
         end
         REL_DB: begin
            if (key_on) begin
               state_d = HELD;
               dcnt_d  = '0;
            end else if (dcnt_q == DCNT_LAST) begin
               state_d      = IDLE;
               dcnt_d       = '0;
               release_ev_d = 1'b1;
            end else begin
               dcnt_d = dcnt_q + DCNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            dcnt_d  = '0;
         end
      endcase
   end

   // FSM state, counters and event flags that line up with state_q.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         dcnt_q       <= '0;
         rcnt_q       <= '0;
         first_q      <= 1'b0;
         press_ev_q   <= 1'b0;
         release_ev_q <= 1'b0;
         repeat_ev_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         dcnt_q       <= dcnt_d;
         rcnt_q       <= rcnt_d;
         first_q      <= first_d;
         press_ev_q   <= press_ev_d;
         release_ev_q <= release_ev_d;
         repeat_ev_q  <= repeat_ev_d;
      end
   end

   // Output stage: level and pulses retimed together so press rises with level.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         repeat_q  <= 1'b0;
      end else begin
         level_q   <= (state_q == HELD) || (state_q == REL_DB);
         press_q   <= press_ev_q;
         release_q <= release_ev_q;
         repeat_q  <= repeat_ev_q;
      end
   end

   assign key_level_o   = level_q;
   assign key_press_o   = press_q;
   assign key_release_o = release_q;
   assign key_repeat_o  = repeat_q;

endmodule

// File: rtl/key_scan.sv
// rtl/key_scan.sv - NKeys independent debounced push-button channels
module key_scan
   import key_scan_pkg::*;
#(
   parameter int unsigned NKeys          = DEF_N_KEYS,
   parameter int unsigned DebounceCycles = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned RepeatEn       = DEF_REPEAT_EN,
   parameter int unsigned RepeatDelay    = DEF_REPEAT_DELAY,
   parameter int unsigned RepeatPeriod   = DEF_REPEAT_PERIOD
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [NKeys-1:0] key_i,
   output logic [NKeys-1:0] key_level_o,
   output logic [NKeys-1:0] key_press_o,
   output logic [NKeys-1:0] key_release_o,
   output logic [NKeys-1:0] key_repeat_o
);

   // One self-contained channel per key; channels share nothing but clock and reset.
   for (genvar g = 0; g < NKeys; g++) begin : g_ch
      key_debounce_ch #(
         .DebounceCycles (DebounceCycles),
         .RepeatEn       (RepeatEn),
         .RepeatDelay    (RepeatDelay),
         .RepeatPeriod   (RepeatPeriod)
      ) u_ch (
         .clk           (clk),
         .rstn          (rstn),
         .key_i         (key_i[g]),
         .key_level_o   (key_level_o[g]),
         .key_press_o   (key_press_o[g]),
         .key_release_o (key_release_o[g]),
         .key_repeat_o  (key_repeat_o[g])
      );
   end

endmodule

// File: tb/tb_key_scan.sv
// tb/tb_key_scan.sv - scoreboard bench for key_scan (repeat on and repeat off instances)
module tb_key_scan;

   localparam int N       = 4;
   localparam int K_PRESS = 0;
   localparam int K_REL   = 1;
   localparam int K_REP   = 2;

   typedef struct {
      int cyc;
      int key;
      int kind;
   } ev_t;

   logic         clk = 1'b0;
   logic         rstn;
   logic [N-1:0] key_i;
   logic [N-1:0] lvl, prs, rel, rep;
   logic [N-1:0] lvl_n, prs_n, rel_n, rep_n;
   logic [N-1:0] exp_lvl;
   int           cyc = 0;
   int           checks = 0;
   int           errors = 0;
   ev_t          exp_q[$];

   key_scan #(
      .NKeys(N), .DebounceCycles(4), .RepeatEn(1), .RepeatDelay(20), .RepeatPeriod(8)
   ) dut (
      .clk(clk), .rstn(rstn), .key_i(key_i),
      .key_level_o(lvl), .key_press_o(prs), .key_release_o(rel), .key_repeat_o(rep)
   );

   key_scan #(
      .NKeys(N), .DebounceCycles(4), .RepeatEn(0), .RepeatDelay(20), .RepeatPeriod(8)
   ) dut_norep (
      .clk(clk), .rstn(rstn), .key_i(key_i),
      .key_level_o(lvl_n), .key_press_o(prs_n), .key_release_o(rel_n), .key_repeat_o(rep_n)
   );

   always #5 clk = ~clk;

   // cyc = number of rising edges so far; sampled on the falling edge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic push_ev(input int c, input int k, input int kind);
      ev_t e;
      e.cyc  = c;
      e.key  = k;
      e.kind = kind;
      exp_q.push_back(e);
   endtask

   task automatic take(input int c, output logic [N-1:0] p, output logic [N-1:0] r,
                       output logic [N-1:0] t);
      p = '0;
      r = '0;
      t = '0;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].cyc == c) begin
            if (exp_q[i].kind == K_PRESS)    p[exp_q[i].key] = 1'b1;
            else if (exp_q[i].kind == K_REL) r[exp_q[i].key] = 1'b1;
            else                             t[exp_q[i].key] = 1'b1;
            exp_q.delete(i);
         end
      end
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic test_reset;
      rstn    = 1'b0;
      key_i   = '1;
      exp_lvl = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({prs, rel, rep, lvl, prs_n, rel_n, rep_n, lvl_n} !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs got=%h exp=00000000",
                  {prs, rel, rep, lvl, prs_n, rel_n, rep_n, lvl_n});
      end
      key_i = '0;
      repeat (8) @(negedge clk);
      checks++;
      if ({prs, rel, rep, lvl, prs_n, rel_n, rep_n, lvl_n} !== 32'h0) begin
         errors++;
         $display("FAIL reset_keys_held got=%h exp=00000000",
                  {prs, rel, rep, lvl, prs_n, rel_n, rep_n, lvl_n});
      end
      key_i = '1;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({prs, rel, rep, lvl} !== 16'h0) begin
            errors++;
            $display("FAIL reset_idle i=%0d got=%h exp=0000", i, {prs, rel, rep, lvl});
         end
      end
   endtask

   task automatic test_clean_press;
      int b, e;
      logic [N-1:0] ep, er, et;
      b = cyc;
      push_ev(b + 16, 0, K_PRESS);
      push_ev(b + 31, 0, K_REL);
      for (int c = b; c <= b + 40; c++) begin
         wait_cyc(c);
         take(c, ep, er, et);
         exp_lvl = (exp_lvl | ep) & ~er;
         checks++;
         if ({prs, rel, rep, lvl} !== {ep, er, et, exp_lvl}) begin
            errors++;
            $display("FAIL clean cyc=%0d got p=%b r=%b t=%b l=%b exp p=%b r=%b t=%b l=%b",
                     c - b, prs, rel, rep, lvl, ep, er, et, exp_lvl);
         end
         checks++;
         if ({prs_n, rel_n, rep_n, lvl_n} !== {ep, er, 4'b0000, exp_lvl}) begin
            errors++;
            $display("FAIL clean_norep cyc=%0d got p=%b r=%b t=%b l=%b exp p=%b r=%b t=0000 l=%b",
                     c - b, prs_n, rel_n, rep_n, lvl_n, ep, er, exp_lvl);
         end
         e = c + 1 - b;
         key_i[0] = (e >= 10 && e <= 24) ? 1'b0 : 1'b1;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL clean_pending got=%0d exp=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_bounce;
      int b, e;
      logic [N-1:0] ep, er, et;
      b = cyc;
      push_ev(b + 36, 1, K_PRESS);
      push_ev(b + 47, 1, K_REL);
      for (int c = b; c <= b + 56; c++) begin
         wait_cyc(c);
         take(c, ep, er, et);
         exp_lvl = (exp_lvl | ep) & ~er;
         checks++;
         if ({prs, rel, rep, lvl} !== {ep, er, et, exp_lvl}) begin
            errors++;
            $display("FAIL bounce cyc=%0d got p=%b r=%b t=%b l=%b exp p=%b r=%b t=%b l=%b",
                     c - b, prs, rel, rep, lvl, ep, er, et, exp_lvl);
         end
         checks++;
         if ({prs_n, rel_n, rep_n, lvl_n} !== {ep, er, 4'b0000, exp_lvl}) begin
            errors++;
            $display("FAIL bounce_norep cyc=%0d got p=%b r=%b t=%b l=%b exp p=%b r=%b t=0000 l=%b",
                     c - b, prs_n, rel_n, rep_n, lvl_n, ep, er, exp_lvl);
         end
         e = c + 1 - b;
         key_i[1] = ((e >= 10 && e <= 12) || (e >= 14 && e <= 16) || (e >= 30 && e <= 40))
                    ? 1'b0 : 1'b1;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL bounce_pending got=%0d exp=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Press at +16, repeats every 8 after +36; the 2-cycle glitch freezes rcnt for
   // 3 edges (HELD->REL_DB, REL_DB, REL_DB->HELD), so the cadence slips by 3.
   task automatic test_repeat_glitch_release;
      int b, e;
      logic [N-1:0] ep, er, et;
      b = cyc;
      push_ev(b + 16, 0, K_PRESS);
      push_ev(b + 36, 0, K_REP);
      push_ev(b + 44, 0, K_REP);
      push_ev(b + 52, 0, K_REP);
      push_ev(b + 63, 0, K_REP);
      push_ev(b + 71, 0, K_REP);
      push_ev(b + 79, 0, K_REP);
      push_ev(b + 87, 0, K_REP);
      push_ev(b + 91, 0, K_REL);
      for (int c = b; c <= b + 100; c++) begin
         wait_cyc(c);
         take(c, ep, er, et);
         exp_lvl = (exp_lvl | ep) & ~er;
         checks++;
         if ({prs, rel, rep, lvl} !== {ep, er, et, exp_lvl}) begin
            errors++;
            $display("FAIL repeat cyc=%0d got p=%b r=%b t=%b l=%b exp p=%b r=%b t=%b l=%b",
                     c - b, prs, rel, rep, lvl, ep, er, et, exp_lvl);
         end
         checks++;
         if ({prs_n, rel_n, rep_n, lvl_n} !== {ep, er, 4'b0000, exp_lvl}) begin
            errors++;
            $display("FAIL repeat_norep cyc=%0d got p=%b r=%b t=%b l=%b exp p=%b r=%b t=0000 l=%b",
                     c - b, prs_n, rel_n, rep_n, lvl_n, ep, er, exp_lvl);
         end
         e = c + 1 - b;
         key_i[0] = ((e >= 10 && e <= 54) || (e >= 57 && e <= 84)) ? 1'b0 : 1'b1;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL repeat_pending got=%0d exp=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_multi_key_reset;
      int b, e;
      logic [N-1:0] ep, er, et;
      b = cyc;
      push_ev(b + 16, 0, K_PRESS);
      push_ev(b + 16, 3, K_PRESS);
      // rstn rises before edge +35, keys still low: press again at +41.
      push_ev(b + 41, 0, K_PRESS);
      push_ev(b + 41, 3, K_PRESS);
      push_ev(b + 56, 0, K_REL);
      push_ev(b + 56, 3, K_REL);
      for (int c = b; c <= b + 64; c++) begin
         wait_cyc(c);
         take(c, ep, er, et);
         exp_lvl = (exp_lvl | ep) & ~er;
         checks++;
         if ({prs, rel, rep, lvl} !== {ep, er, et, exp_lvl}) begin
            errors++;
            $display("FAIL multi cyc=%0d got p=%b r=%b t=%b l=%b exp p=%b r=%b t=%b l=%b",
                     c - b, prs, rel, rep, lvl, ep, er, et, exp_lvl);
         end
         checks++;
         if ({prs_n, rel_n, rep_n, lvl_n} !== {ep, er, 4'b0000, exp_lvl}) begin
            errors++;
            $display("FAIL multi_norep cyc=%0d got p=%b r=%b t=%b l=%b exp p=%b r=%b t=0000 l=%b",
                     c - b, prs_n, rel_n, rep_n, lvl_n, ep, er, exp_lvl);
         end
         e = c + 1 - b;
         key_i[0] = (e >= 10 && e <= 49) ? 1'b0 : 1'b1;
         key_i[3] = (e >= 10 && e <= 49) ? 1'b0 : 1'b1;
         if (c == b + 29) begin
            rstn = 1'b0;
            #1;
            exp_lvl = '0;
            checks++;
            if ({prs, rel, rep, lvl, prs_n, rel_n, rep_n, lvl_n} !== 32'h0) begin
               errors++;
               $display("FAIL multi_async_reset got=%h exp=00000000",
                        {prs, rel, rep, lvl, prs_n, rel_n, rep_n, lvl_n});
            end
         end
         if (c == b + 34) rstn = 1'b1;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL multi_pending got=%0d exp=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_repeat_glitch_release();
      test_multi_key_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/key_scan.md
Name: key_scan

Overview:
- Input-side counterpart of the 7-segment output path. Converts raw active-low push-buttons into clean per-key events for the board top level.
- Per key, the chain is: 2-flop synchronizer, then integrating debounce, then debounced level, then one-cycle press and release pulses, then optional auto-repeat pulses while held.
- Feeds counters/LED logic in place of sampling raw keys every clock.

Parameters:
- NKeys, 4, number of independent key channels.
- DebounceCycles, 1000000, consecutive stable cycles needed to accept a change (20 ms at 50 MHz); must be ≥2.
- RepeatEn, 1, 1 enables auto-repeat; 0 forces key_repeat_o to 0.
- RepeatDelay, 25000000, cycles from the press pulse to the first repeat pulse (500 ms); ≥2.
- RepeatPeriod, 5000000, cycles between subsequent repeat pulses (100 ms); ≥2.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- key_i  input  NKeys  raw buttons, active-low, asynchronous to clk.
- key_level_o  output  NKeys  debounced state, 1 = pressed.
- key_press_o  output  NKeys  one-cycle pulse on accepted press.
- key_release_o  output  NKeys  one-cycle pulse on accepted release.
- key_repeat_o  output  NKeys  one-cycle pulse per auto-repeat tick.

Behaviour:
- Reset (rstn low, async): synchronizer flops = 1 (released). All channel FSMs go to IDLE. All counters = 0. All outputs = 0.
- Reset mid-hold produces no release pulse.
- Channels are fully independent. Simultaneous events on different keys are all reported in the same cycle.
- Sync: s = ~sync2, where sync2 is the second flop. Raw change first sampled at edge k is visible to the FSM at edge k+2.
- Per-channel FSM, with dcnt sized $clog2(DebounceCycles):
  - IDLE: if s=1, go to PRESS_DB with dcnt=1.
  - PRESS_DB:
    - s=0: go to IDLE, dcnt=0. Bounce restarts the window.
    - s=1 and dcnt=DebounceCycles-1: go to HELD, rcnt=0, first=1.
    - otherwise: dcnt+1.
  - HELD:
    - s=0: go to REL_DB with dcnt=1. rcnt holds its value.
    - otherwise, if RepeatEn, rcnt+1. When rcnt = (first ? RepeatDelay-1 : RepeatPeriod-1): assert a repeat pulse, set rcnt=0, first=0.
  - REL_DB:
    - s=1: return to HELD, rcnt resumes from its held value. No pulses are emitted.
    - s=0 and dcnt=DebounceCycles-1: go to IDLE.
    - otherwise: dcnt+1.
- Outputs are registered:
  - key_level_o = 1 in HELD and REL_DB.
  - key_press_o is high exactly the first cycle of HELD entered from PRESS_DB.
  - key_release_o is high the first cycle of IDLE entered from REL_DB.
  - key_repeat_o is high the cycle after the matching rcnt edge.
- Latency, clean input: press_o asserts DebounceCycles+2 edges after the first edge sampling key low. Release latency is the same.
- Repeat timing: first repeat_o comes RepeatDelay cycles after press_o, then every RepeatPeriod cycles while in HELD.
- No repeat in PRESS_DB, REL_DB or IDLE. repeat_o never coincides with press_o or release_o on the same key.
- Counter widths: dcnt is $clog2(DebounceCycles); rcnt is $clog2(max(RepeatDelay,RepeatPeriod)). Counters never wrap; they are compared, then cleared.

Decomposition:
- Package key_scan_pkg holds:
  - typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} key_state_t;
  - default timing localparams for a 50 MHz board clock.
- Sub-module key_debounce_ch: one channel, containing the synchronizer, FSM, both counters and 4 registered outputs.
- key_scan instantiates NKeys copies via a generate loop.

Test Plan (DebounceCycles=4, RepeatDelay=20, RepeatPeriod=8, NKeys=4):
- Clean press: key_i[0] low from edge 10, held 15 cycles. Expect press_o[0] high only after edge 16, level_o[0]=1 from edge 16. No other key toggles.
- Bounce: key_i[1] low 3 cycles, high 1, low 3, high 1, then low steady from edge 30. Expect no press_o before press_o[1] after edge 36.
- Auto-repeat: press accepted at edge P, held 60 cycles. Expect repeat_o at P+20, P+28, P+36, ... and none in PRESS_DB. With RepeatEn=0, repeat_o stays 0.
- Release glitch: while HELD, key_i[0] high for 2 cycles, then low. Expect no release_o, level_o stays 1, and the repeat cadence is shifted by only the REL_DB dwell.
- Release: after a steady high from edge R, expect release_o after edge R+6, level_o=0, and no further repeats.
- Multi-key and reset: keys 0 and 3 pressed on the same edge give simultaneous press_o bits 0 and 3. Assert rstn low mid-hold: all outputs drop immediately with no release pulse. With the key still held after rstn rises at edge T, expect press_o after edge T+6.
